// File: rtl/prach_avst_packer.sv
// rtl/prach_avst_packer.sv - packs per-channel PRACH IQ samples into 128-bit Avalon-ST packets
// Optional PRACH_PACKER_SEQNUM_EN: per-channel 8-bit packet sequence number on avst_source_channel[15:8].
module prach_avst_packer #(
    parameter int NUM_CHN    = 24,
    parameter int PKT_BEATS  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync_in,
    input  logic [15:0]                   din_dq,
    input  logic                          din_dv,
    input  logic [7:0]                    din_chn,
    output logic [127:0]                  avst_source_data,
    output logic                          avst_source_valid,
    output logic [15:0]                   avst_source_channel,
    output logic                          avst_source_startofpacket,
    output logic                          avst_source_endofpacket,
    input  logic                          avst_source_ready,
    output logic                          overflow_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW    = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int BW    = $clog2(PKT_BEATS);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [7:0]       NUM_CHN_C = 8'(NUM_CHN);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(PKT_BEATS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [7:0]   seq;
        logic [7:0]   chn;
        logic [127:0] data;
    } beat_t;

    // Lane 7 is never stored: the 8th sample goes straight into the pushed beat.
    logic [6:0][15:0] lane_q [NUM_CHN];
    logic [6:0][15:0] lane_d [NUM_CHN];
    logic [2:0]       lc_q   [NUM_CHN];
    logic [2:0]       lc_d   [NUM_CHN];
    logic [BW-1:0]    bc_q   [NUM_CHN];
    logic [BW-1:0]    bc_d   [NUM_CHN];
`ifdef PRACH_PACKER_SEQNUM_EN
    logic [7:0]       seq_q  [NUM_CHN];
    logic [7:0]       seq_d  [NUM_CHN];
`endif

    logic             push_q, push_d;
    beat_t            pbeat_q, pbeat_d;

    beat_t            mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             in_ok;
    logic [CW-1:0]    idx;
    logic [2:0]       cur_lc;
    logic [BW-1:0]    cur_bc;
    logic             pop, full, wr_en;
    beat_t            head;

    // Sync clears counters first, so a sample arriving with sync lands in lane 0.
    always_comb begin
        lc_d    = lc_q;
        bc_d    = bc_q;
        lane_d  = lane_q;
`ifdef PRACH_PACKER_SEQNUM_EN
        seq_d   = seq_q;
`endif
        push_d  = 1'b0;
        pbeat_d = pbeat_q;
        in_ok   = din_dv && (din_chn < NUM_CHN_C);
        idx     = din_chn[CW-1:0];
        cur_lc  = sync_in ? 3'd0 : lc_q[idx];
        cur_bc  = sync_in ? '0 : bc_q[idx];
        if (sync_in) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                lc_d[c] = '0;
                bc_d[c] = '0;
            end
        end
        if (in_ok) begin
            if (cur_lc == 3'd7) begin
                push_d       = 1'b1;
                pbeat_d.data = {din_dq, lane_q[idx]};
                pbeat_d.chn  = din_chn;
                pbeat_d.sop  = (cur_bc == '0);
                pbeat_d.eop  = (cur_bc == LAST_BEAT);
                pbeat_d.seq  = 8'd0;
`ifdef PRACH_PACKER_SEQNUM_EN
                pbeat_d.seq  = seq_q[idx];
                if (cur_bc == LAST_BEAT) begin
                    seq_d[idx] = seq_q[idx] + 8'd1;
                end
`endif
                lc_d[idx] = 3'd0;
                bc_d[idx] = (cur_bc == LAST_BEAT) ? '0 : cur_bc + BW'(1);
            end else begin
                lane_d[idx][cur_lc] = din_dq;
                lc_d[idx]           = cur_lc + 3'd1;
            end
        end
    end

    // A push into a full FIFO still wins when the head pops in the same cycle.
    always_comb begin
        pop      = (count_q != '0) && avst_source_ready;
        full     = (count_q == DEPTH_C);
        wr_en    = push_q && (!full || pop);
        ovf_d    = ovf_q | (push_q && full && !pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                lc_q[c]   <= '0;
                bc_q[c]   <= '0;
                lane_q[c] <= '0;
`ifdef PRACH_PACKER_SEQNUM_EN
                seq_q[c]  <= '0;
`endif
            end
            push_q   <= 1'b0;
            pbeat_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            lc_q     <= lc_d;
            bc_q     <= bc_d;
            lane_q   <= lane_d;
`ifdef PRACH_PACKER_SEQNUM_EN
            seq_q    <= seq_d;
`endif
            push_q   <= push_d;
            pbeat_q  <= pbeat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= pbeat_q;
        end
    end

    // Head fields are masked when empty so the bus reads all-zero after reset.
    assign head                      = mem_q[rd_ptr_q];
    assign avst_source_valid         = (count_q != '0);
    assign avst_source_data          = avst_source_valid ? head.data : '0;
    assign avst_source_channel       = avst_source_valid ? {head.seq, head.chn} : '0;
    assign avst_source_startofpacket = avst_source_valid & head.sop;
    assign avst_source_endofpacket   = avst_source_valid & head.eop;
    assign overflow_err              = ovf_q;
    assign fifo_level                = count_q;

endmodule

// File: tb/tb_prach_avst_packer.sv
// tb/tb_prach_avst_packer.sv - directed self-checking bench for prach_avst_packer
module tb_prach_avst_packer;
    localparam int NUM_CHN    = 24;
    localparam int PKT_BEATS  = 16;
    localparam int FIFO_DEPTH = 64;
`ifdef PRACH_PACKER_SEQNUM_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, sync_in, din_dv, ready;
    logic [15:0]  din_dq;
    logic [7:0]   din_chn;
    logic [127:0] data;
    logic         valid, sop, eop, ovf;
    logic [15:0]  chan;
    logic [6:0]   level;

    always #5 clk = ~clk;

    prach_avst_packer #(
        .NUM_CHN(NUM_CHN), .PKT_BEATS(PKT_BEATS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
        .avst_source_data(data), .avst_source_valid(valid),
        .avst_source_channel(chan), .avst_source_startofpacket(sop),
        .avst_source_endofpacket(eop), .avst_source_ready(ready),
        .overflow_err(ovf), .fifo_level(level)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  chn;
        logic         sop;
        logic         eop;
    } obs_t;
    obs_t got[$];

    always @(negedge clk) begin
        obs_t b;
        if (!rst && valid && ready) begin
            b.data = data;
            b.chn  = chan;
            b.sop  = sop;
            b.eop  = eop;
            got.push_back(b);
        end
    end

    typedef struct {
        logic        sync;
        logic        dv;
        logic [7:0]  chn;
        logic [15:0] dq;
        logic        rdy;
        logic        exp_v;
        logic [6:0]  exp_lvl;
    } vec_t;
    vec_t tbl[22];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_seq(input logic [15:0] base);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(k);
        return r;
    endfunction

    task automatic chk_beat(input string name, input int i, input logic [15:0] c,
                            input logic s, input logic e, input logic [127:0] d);
        if (i >= got.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s[%0d]: beat missing, got %0d beats", name, i, got.size());
        end else begin
            check($sformatf("%s[%0d]", name, i),
                  {got[i].chn, got[i].sop, got[i].eop, got[i].data}, {c, s, e, d});
        end
    endtask

    task automatic idle(input int n);
        din_dv  = 1'b0;
        sync_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] v);
        din_dv  = 1'b1;
        din_chn = c;
        din_dq  = v;
        sync_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first;
        logic [127:0] d;
        logic [7:0] sq;

        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 8'd2, 16'(16'hA000 + i), 1'b1, 1'b0, 7'd0};
        tbl[3] = '{1'b1, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 7'd0};
        for (int i = 4; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 8'd2, 16'(16'hB000 + i - 4), 1'b1, 1'b0, 7'd0};
        for (int i = 12; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 8'd30, 16'(16'hD000 + i), 1'b1, 1'b0, 7'd0};
        tbl[13] = '{1'b0, 1'b1, 8'd30, 16'hD00D, 1'b0, 1'b1, 7'd1};
        tbl[14] = '{1'b0, 1'b1, 8'd30, 16'hD00E, 1'b1, 1'b1, 7'd1};
        for (int i = 20; i < 22; i++) tbl[i] = '{1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 1'b0, 7'd0};

        rst = 1'b1; sync_in = 1'b0; din_dv = 1'b0; din_chn = '0; din_dq = '0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_chan", chan, 0);
        check("rst_sop_eop", {sop, eop}, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic packet on channel 5
        got.delete();
        first = -1;
        for (int i = 0; i < 128; i++) begin
            din_dv = 1'b1; din_chn = 8'd5; din_dq = 16'(i);
            @(negedge clk);
            if (valid && first < 0) first = i;
            @(posedge clk);
            #1;
        end
        idle(6);
        check("basic_latency", first, 9);
        check("basic_count", got.size(), 16);
        for (int b = 0; b < 16; b++)
            chk_beat("basic", b, 16'd5, b == 0, b == 15, mk_seq(16'(b * 8)));

        // TDM interleave
        got.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < NUM_CHN; c++) send(8'(c), {8'(r), 8'(c)});
        idle(4);
        check("tdm_count", got.size(), 24);
        for (int c = 0; c < NUM_CHN; c++) begin
            for (int k = 0; k < 8; k++) d[16*k +: 16] = {8'(k), 8'(c)};
            sq = (SEQ_EN && c == 5) ? 8'd1 : 8'd0;
            chk_beat("tdm", c, {sq, 8'(c)}, 1'b1, 1'b0, d);
        end

        // sync mid-beat and invalid channel, cycle by cycle
        got.delete();
        for (int r = 0; r < 22; r++) begin
            sync_in = tbl[r].sync; din_dv = tbl[r].dv; din_chn = tbl[r].chn;
            din_dq = tbl[r].dq; ready = tbl[r].rdy;
            @(negedge clk);
            check($sformatf("tbl_valid[%0d]", r), valid, tbl[r].exp_v);
            check($sformatf("tbl_level[%0d]", r), level, tbl[r].exp_lvl);
            @(posedge clk);
            #1;
        end
        idle(2);
        check("sync_count", got.size(), 1);
        chk_beat("sync", 0, 16'd2, 1'b1, 1'b0, mk_seq(16'hB000));

        // backpressure: 10 beats held
        got.delete();
        ready = 1'b0;
        for (int i = 0; i < 80; i++) send(8'd7, 16'(16'h7000 + i));
        idle(3);
        @(negedge clk);
        check("bp_level", level, 10);
        check("bp_head", {valid, chan, sop, eop, data}, {1'b1, 16'd7, 1'b1, 1'b0, mk_seq(16'h7000)});
        @(posedge clk);
        #1;
        idle(4);
        @(negedge clk);
        check("bp_stable", {valid, chan, sop, eop, data}, {1'b1, 16'd7, 1'b1, 1'b0, mk_seq(16'h7000)});
        check("bp_nopop", got.size(), 0);
        @(posedge clk);
        #1;
        ready = 1'b1;
        idle(14);
        check("bp_count", got.size(), 10);
        check("bp_level_drained", level, 0);
        for (int b = 0; b < 10; b++)
            chk_beat("bp", b, 16'd7, b == 0, 1'b0, mk_seq(16'(16'h7000 + 8 * b)));

        // overflow: 65 pushes into 64 entries
        got.delete();
        ready = 1'b0;
        for (int j = 0; j < 64; j++)
            for (int k = 0; k < 8; k++) send(8'd9, 16'(j * 8 + k));
        idle(3);
        @(negedge clk);
        check("ovf_full_level", level, 64);
        check("ovf_not_yet", ovf, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send(8'd9, 16'(512 + k));
        idle(3);
        @(negedge clk);
        check("ovf_set", ovf, 1);
        check("ovf_level", level, 64);
        @(posedge clk);
        #1;
        ready = 1'b1;
        idle(70);
        for (int j = 65; j < 80; j++)
            for (int k = 0; k < 8; k++) send(8'd9, 16'(j * 8 + k));
        idle(5);
        check("ovf_count", got.size(), 79);
        check("ovf_sticky", ovf, 1);
        for (int i = 0; i < 79; i++) begin
            int j;
            j = (i < 64) ? i : i + 1;
            sq = SEQ_EN ? 8'(j / 16) : 8'd0;
            chk_beat("ovf", i, {sq, 8'd9}, (j % 16) == 0, (j % 16) == 15, mk_seq(16'(j * 8)));
        end

        // sequence numbers on channel 1 (zero when the feature is off)
        got.delete();
        for (int i = 0; i < 384; i++) send(8'd1, 16'(16'h1000 + i));
        idle(4);
        check("seq_count", got.size(), 48);
        for (int b = 0; b < 48; b++) begin
            sq = SEQ_EN ? 8'(b / 16) : 8'd0;
            chk_beat("seq", b, {sq, 8'd1}, (b % 16) == 0, (b % 16) == 15, mk_seq(16'(16'h1000 + 8 * b)));
        end

        // reset mid-packet
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'd3, 16'(16'h3000 + i));
        idle(3);
        @(negedge clk);
        check("rstmid_level_before", level, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", valid, 0);
        check("rstmid_level", level, 0);
        check("rstmid_ovf", ovf, 0);
        @(posedge clk);
        #1;
        got.delete();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd3, 16'(16'h3100 + i));
        idle(4);
        check("rstmid_count", got.size(), 1);
        chk_beat("rstmid", 0, 16'd3, 1'b1, 1'b0, mk_seq(16'h3100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prach_avst_packer.md
# prach_avst_packer

Packs the decimated PRACH IQ sample stream from `prach_ddc` into 128-bit Avalon-ST packets with per-channel framing. It drives the `avst_source_*` interface that feeds the eth/xRAN side. Per-channel lane buffers collect eight 16-bit samples per beat. Beats go into an output FIFO that absorbs `avst_source_ready` backpressure. Each packet is `PKT_BEATS` beats of one channel; packets of different channels may interleave on the bus, tagged by the channel field.

## Interface
- `NUM_CHN`, 24, number of TDM channels (ant*3+cc); valid `din_chn` is 0..NUM_CHN-1
- `PKT_BEATS`, 16, beats per packet (≥2)
- `FIFO_DEPTH`, 64, output FIFO depth in beats (power of 2)
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `sync_in`  in  1  frame sync from DDC (`ddc_sync_out`), one-cycle pulse
- `din_dq`  in  16  sample (I or Q word as produced by DDC)
- `din_dv`  in  1  sample valid
- `din_chn`  in  8  sample channel
- `avst_source_data`  out  128  beat, sample k in bits [16k+15:16k], k=0 oldest
- `avst_source_valid`  out  1  beat valid
- `avst_source_channel`  out  16  [7:0] channel, [15:8] see Configuration
- `avst_source_startofpacket`  out  1  first beat of packet
- `avst_source_endofpacket`  out  1  last beat of packet
- `avst_source_ready`  in  1  sink ready, readyLatency 0
- `overflow_err`  out  1  sticky: a beat was dropped on full FIFO
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Per channel state:
  - lane counter `lc[c]` (0..7)
  - beat counter `bc[c]` (0..PKT_BEATS-1)
  - 128-bit lane buffer (RAM or regs)
- Sample accept (`din_dv`=1, `din_chn`<NUM_CHN):
  - write `din_dq` to lane `lc[c]` of buffer c; `lc[c]` increments and wraps 7→0.
- Samples with `din_chn`≥NUM_CHN are ignored; no state changes.
- On the 8th lane (`lc[c]`=7), push one beat into the FIFO:
  - data: full buffer, with the current sample in lane 7
  - channel: c
  - sop: `bc[c]`=0
  - eop: `bc[c]`=PKT_BEATS-1
- `bc[c]` advances modulo PKT_BEATS on every push attempt, including dropped ones, so framing stays fixed.
- FIFO full on a push attempt:
  - the beat is dropped and `overflow_err` is set; it stays set until `rst`.
  - a push and a pop in the same cycle while full: the push succeeds.
- `sync_in`=1:
  - clear all `lc` and `bc` to 0; partially filled beats are discarded.
  - the FIFO is not flushed; a packet already partially queued is left truncated (no eop).
  - if `din_dv` is also 1 in that cycle, the sample is taken as lane 0 after the clear.
- Output is the FIFO head (show-ahead). It pops on `avst_source_valid && avst_source_ready`. The output holds stable while valid=1 and ready=0.

## Timing
- Reset values:
  - all outputs 0
  - FIFO empty
  - all counters 0
  - `overflow_err`=0
- Latency: 8th sample of a beat at cycle t → push registered at t+1 → `avst_source_valid`=1 at t+2 when the FIFO was empty.
- Throughput: one push per cycle max (one input sample per cycle) and one pop per cycle.
- `fifo_level` is updated the cycle after the push or pop.
- `rst` mid-packet: the FIFO is emptied and valid drops the next cycle. There is no tail beat and no eop.

## Configuration
- `PRACH_PACKER_SEQNUM_EN` defined:
  - per channel, an 8-bit packet sequence counter increments (wrap 255→0) on each eop push attempt.
  - `avst_source_channel[15:8]` carries the sequence number of the beat's packet.
  - the counters are cleared by `rst` only; `sync_in` does not clear them.
- Not defined: no sequence counters are built and `avst_source_channel[15:8]`=0.

## Test plan
- Single channel, basic packet: PKT_BEATS=16, ready=1; feed chn 5 with samples 0..127, one per cycle. Required response:
  - 16 beats with channel=5; sop on beat 0, eop on beat 15.
  - beat 0 data lanes = 0..7; lane 0 in bits [15:0].
  - first valid 2 cycles after sample 7.
- TDM interleave: chn 0..23 round-robin, 8 rounds. Required response:
  - 24 beats, channels 0..23 in order.
  - each beat has sop=1 and lane k = round k's sample.
- Backpressure: hold ready=0 during 10 pushes. Required response:
  - `fifo_level`=10; valid=1 with data stable.
  - release ready → 10 beats out in order, no loss.
- Overflow: FIFO_DEPTH=64, ready=0, 65 pushes. Required response:
  - `overflow_err`=1 and `fifo_level`=64; the 65th beat is dropped.
  - the next pushed beat of that channel still carries the correct sop/eop position.
- Sync mid-beat: send 3 samples to chn 2, pulse `sync_in`, then 8 samples. Required response: one beat with the post-sync samples only and sop=1.
- Invalid channel and sequence number: samples with chn=30 → no beats. With `PRACH_PACKER_SEQNUM_EN`, chn 1 for 3 packets → `avst_source_channel[15:8]`=0,1,2.
